// File: rtl/ifetch_axi_bridge.sv
// ---------------------------------------------------------------------------
// ifetch_axi_bridge
//
// Fetch-side responder for the CPU IF stage. For every PC presented on
// inst_pc_i the bridge issues one single-beat AXI4 read, buffers the
// returned word in inst_o and pulses ifid_en_o for one cycle. That pulse
// lets the pipeline advance. The pulse is held off while the data-side memory
// port reports busy, so fetch and load/store complete in lock-step.
//
// Ports
//   clk, rst        : single clock, asynchronous active-high reset
//   inst_pc_i       : PC requested by the IF stage (stable while ifid_en_o=0)
//   inst_o          : registered instruction word for the IF stage
//   ifid_en_o       : one-cycle pulse, inst_o valid, pipeline may advance
//   fetch_err_o     : with ifid_en_o, captured beat had a non-OKAY response
//   dmem_busy_i     : data-side memory port has an outstanding transfer
//   AR*_M / R*_M    : AXI4 read-address / read-data channels (master side)
// ---------------------------------------------------------------------------
module ifetch_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] inst_pc_i,
    output logic [31:0] inst_o,
    output logic        ifid_en_o,
    output logic        fetch_err_o,
    input  logic        dmem_busy_i,

    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,

    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q,  inst_d;
    logic        err_q,   err_d;

    // RID is not needed: only one read is ever outstanding.
    logic        unused_rid;
    assign unused_rid = ^RID_M;

    // Any response other than OKAY marks the fetched word as faulty.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    // The last beat in R is the only point where the instruction is captured.
    logic        r_capture_s;
    assign r_capture_s = (state_q == S_R) && RVALID_M && RLAST_M;

    // State, instruction buffer and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            inst_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_AR;
            end
            S_AR: begin
                if (ARREADY_M) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                // A beat without RLAST is accepted and dropped; keep waiting.
                if (r_capture_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_R;
                end
            end
            S_WAIT: begin
                // Leave WAIT on the same edge the IF stage loads its new PC.
                if (!dmem_busy_i) begin
                    state_d = S_AR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction buffer and error flag update: hold unless capturing.
    always_comb begin
        inst_d = inst_q;
        err_d  = err_q;
        if (r_capture_s) begin
            inst_d = RDATA_M;
            err_d  = resp_is_err(RRESP_M);
        end else begin
            inst_d = inst_q;
            err_d  = err_q;
        end
    end

    // Handshake and pipeline-enable outputs decoded from the state register.
    always_comb begin
        ARVALID_M   = 1'b0;
        RREADY_M    = 1'b0;
        ifid_en_o   = 1'b0;
        fetch_err_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ARVALID_M = 1'b0;
            end
            S_AR: begin
                ARVALID_M = 1'b1;
            end
            S_R: begin
                RREADY_M = 1'b1;
            end
            S_WAIT: begin
                ifid_en_o   = ~dmem_busy_i;
                fetch_err_o = err_q & ~dmem_busy_i;
            end
            default: begin
                ARVALID_M = 1'b0;
            end
        endcase
    end

    // Address is taken straight from the PC; the PC is frozen in AR and R.
    assign ARADDR_M  = inst_pc_i;
    assign ARID_M    = AXI_ID;
    assign ARLEN_M   = 4'd0;
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = 2'b01;
    assign inst_o    = inst_q;

endmodule

// File: tb/tb_ifetch_axi_bridge.sv
// ---------------------------------------------------------------------------
// Directed bench for ifetch_axi_bridge: a small AXI read slave with
// configurable ARREADY/RVALID delays, an IF-stage PC model and a dmem busy
// generator. Outputs are sampled 2 time units after each rising edge.
// ---------------------------------------------------------------------------
module tb_ifetch_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_pc_i = 32'd0;
    logic [31:0] inst_o;
    logic        ifid_en_o;
    logic        fetch_err_o;
    logic        dmem_busy_i = 1'b0;
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M = 1'b0;
    logic [3:0]  RID_M = 4'd0;
    logic [31:0] RDATA_M = 32'd0;
    logic [1:0]  RRESP_M = 2'b00;
    logic        RLAST_M = 1'b0;
    logic        RVALID_M = 1'b0;
    logic        RREADY_M;

    ifetch_axi_bridge #(.AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .inst_pc_i(inst_pc_i), .inst_o(inst_o), .ifid_en_o(ifid_en_o),
        .fetch_err_o(fetch_err_o), .dmem_busy_i(dmem_busy_i),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
        .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M),
        .ARREADY_M(ARREADY_M), .RID_M(RID_M), .RDATA_M(RDATA_M),
        .RRESP_M(RRESP_M), .RLAST_M(RLAST_M), .RVALID_M(RVALID_M),
        .RREADY_M(RREADY_M)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          en_cyc   = 0;

    // slave / environment model state
    int          ar_cnt = 0, r_cnt = 0, busy_left = 0;
    int          cfg_ar = 0, cfg_r = 0, cfg_busy = 0;
    bit          cfg_stray = 1'b0, cfg_busy_ar = 1'b0;
    logic [31:0] cfg_data = 32'd0;
    logic [1:0]  cfg_resp = 2'b00;
    logic        r_pending = 1'b0;
    logic        prev_en = 1'b0, prev_ar_hs = 1'b0, prev_r_hs = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] inst_exp = 32'd0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive slave and environment inputs for the current cycle.
    task automatic drive();
        inst_pc_i = pc;
        if (ARVALID_M) begin
            ARREADY_M = (ar_cnt >= cfg_ar);
            ar_cnt++;
        end else begin
            ARREADY_M = 1'b0;
            ar_cnt    = 0;
        end
        RVALID_M = 1'b0; RLAST_M = 1'b0; RDATA_M = 32'd0; RRESP_M = 2'b00;
        if (r_pending) begin
            if (r_cnt >= cfg_r) begin
                RVALID_M = 1'b1; RLAST_M = 1'b1; RDATA_M = cfg_data; RRESP_M = cfg_resp;
            end
            r_cnt++;
        end else if (cfg_stray && ARVALID_M) begin
            RVALID_M = 1'b1; RLAST_M = 1'b1; RDATA_M = 32'hBAD0BAD0; RRESP_M = 2'b10;
        end
        dmem_busy_i = (busy_left > 0) || (cfg_busy_ar && (ARVALID_M || RREADY_M));
        if (busy_left > 0) busy_left--;
    endtask

    // Advance one clock, update models from last cycle's handshakes, drive, sample.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_en)    pc = pc + 32'd4;
        if (prev_ar_hs) begin r_pending = 1'b1; r_cnt = 0; end
        if (prev_r_hs)  begin r_pending = 1'b0; busy_left = cfg_busy; end
        drive();
        #1;
        prev_en    = ifid_en_o;
        prev_ar_hs = ARVALID_M & ARREADY_M;
        prev_r_hs  = RVALID_M & RREADY_M & RLAST_M;
    endtask

    // One fetch starting with the step into AR; checks latency from AR to pulse.
    task automatic run_fetch(input string tag, input logic [31:0] exp_pc,
                             input logic [31:0] data, input logic [1:0] resp,
                             input int ar_d, input int r_d, input int busy,
                             input bit stray, input bit busy_ar,
                             input int exp_lat, input logic exp_err);
        int  start;
        bit  done;
        bit  captured;
        cfg_data = data; cfg_resp = resp; cfg_ar = ar_d; cfg_r = r_d;
        cfg_busy = busy; cfg_stray = stray; cfg_busy_ar = busy_ar;
        step();
        check({tag, "_arvalid_first"}, 32'(ARVALID_M), 32'd1);
        start    = cyc;
        done     = 1'b0;
        captured = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0) step();
            if (ifid_en_o) begin
                done = 1'b1;
            end else begin
                if (ARVALID_M) check({tag, "_araddr"}, ARADDR_M, exp_pc);
                check({tag, "_inst_hold"}, inst_o, captured ? data : inst_exp);
                check({tag, "_err_low"}, 32'(fetch_err_o), 32'd0);
                if (RVALID_M && RREADY_M && RLAST_M) captured = 1'b1;
            end
        end
        check({tag, "_pulse_seen"}, 32'(done), 32'd1);
        if (done) begin
            en_cyc = cyc;
            check({tag, "_latency"}, 32'(cyc - start), 32'(exp_lat));
            check({tag, "_inst"}, inst_o, data);
            check({tag, "_fetch_err"}, 32'(fetch_err_o), 32'(exp_err));
        end
        inst_exp = data;
        cfg_stray = 1'b0; cfg_busy_ar = 1'b0; cfg_busy = 0;
    endtask

    // Apply reset, check reset values, release and check the IDLE cycle.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        r_pending = 1'b0; ar_cnt = 0; r_cnt = 0; busy_left = 0;
        prev_en = 1'b0; prev_ar_hs = 1'b0; prev_r_hs = 1'b0;
        cfg_stray = 1'b0; cfg_busy_ar = 1'b0; cfg_busy = 0;
        pc = 32'd0; inst_exp = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_rst_inst"},    inst_o, 32'd0);
        check({tag, "_rst_arvalid"}, 32'(ARVALID_M), 32'd0);
        check({tag, "_rst_rready"},  32'(RREADY_M), 32'd0);
        check({tag, "_rst_en"},      32'(ifid_en_o), 32'd0);
        check({tag, "_rst_err"},     32'(fetch_err_o), 32'd0);
        rst = 1'b0;
        cyc = 1;
        drive();
        #1;
        check({tag, "_idle_arvalid"}, 32'(ARVALID_M), 32'd0);
        check({tag, "_idle_en"},      32'(ifid_en_o), 32'd0);
    endtask

    initial begin
        // Reset and zero-wait first fetch: AR in cycle 2, pulse in cycle 4.
        do_reset("t1");
        check("t1_arid",    32'(ARID_M), 32'd0);
        check("t1_arlen",   32'(ARLEN_M), 32'd0);
        check("t1_arsize",  32'(ARSIZE_M), 32'd2);
        check("t1_arburst", 32'(ARBURST_M), 32'd1);
        run_fetch("t1", 32'h0, 32'h00000013, 2'b00, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0);
        check("t1_en_cycle", 32'(en_cyc), 32'd4);

        // ARREADY +3, RVALID +2: five cycles later than zero-wait; PC now 0x4.
        run_fetch("t2", 32'h4, 32'h00100093, 2'b00, 3, 2, 0, 1'b0, 1'b0, 7, 1'b0);

        // dmem busy for 4 cycles after capture.
        run_fetch("t3", 32'h8, 32'h00208113, 2'b00, 0, 0, 4, 1'b0, 1'b0, 6, 1'b0);

        // SLVERR response, then OKAY clears the error.
        run_fetch("t4", 32'hC,  32'hDEADBEEF, 2'b10, 0, 0, 0, 1'b0, 1'b0, 2, 1'b1);
        run_fetch("t4b", 32'h10, 32'h00000033, 2'b00, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0);

        // Reset while in R with RVALID pending.
        cfg_ar = 0; cfg_r = 0; cfg_data = 32'h12345678; cfg_resp = 2'b00;
        step();
        check("t5_in_ar", 32'(ARVALID_M), 32'd1);
        step();
        check("t5_in_r_rready", 32'(RREADY_M), 32'd1);
        check("t5_in_r_rvalid", 32'(RVALID_M), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_async_rready", 32'(RREADY_M), 32'd0);
        check("t5_async_inst",   inst_o, 32'd0);
        check("t5_async_en",     32'(ifid_en_o), 32'd0);
        do_reset("t5");
        run_fetch("t5", 32'h0, 32'h00000013, 2'b00, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0);
        check("t5_en_cycle", 32'(en_cyc), 32'd4);

        // Stray RVALID during a 3-cycle AR phase must be ignored.
        run_fetch("t6", 32'h4, 32'h00400213, 2'b00, 2, 0, 0, 1'b1, 1'b0, 4, 1'b0);

        // dmem busy toggling during AR/R only: no extra latency.
        run_fetch("t7", 32'h8, 32'h0000006F, 2'b00, 0, 0, 0, 1'b0, 1'b1, 2, 1'b0);

        step();
        check("end_single_pulse", 32'(ifid_en_o), 32'd0);
        check("end_next_ar",      32'(ARVALID_M), 32'd1);
        check("end_next_pc",      ARADDR_M, 32'hC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_axi_bridge.md
# ifetch_axi_bridge

Fetch-side responder for the CPU IF stage. Serves each instruction request implied by the IF stage's current PC (`inst_pc_o`) by issuing one single-beat AXI4 read on the instruction master port. It buffers the returned word and drives the `inst_i`/`ifid_en_i` pair back into the IF stage. It also holds the pipeline-advance enable low while the data-side memory port reports busy, so fetch and load/store complete in lock-step.

## Interface
Parameters:
- `AXI_ID`, default `4'd0`: constant driven on `ARID_M`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_pc_i`  in  32  PC requested by the IF stage. Stable whenever `ifid_en_o`=0.
- `inst_o`  out  32  registered instruction word returned to the IF stage.
- `ifid_en_o`  out  1  one-cycle pulse: `inst_o` is valid for `inst_pc_i`; pipeline may advance.
- `fetch_err_o`  out  1  high together with `ifid_en_o` when the captured beat had `RRESP` ≠ OKAY.
- `dmem_busy_i`  in  1  data-side memory port has an outstanding transfer.
- `ARID_M`  out  4  always `AXI_ID`.
- `ARADDR_M`  out  32  equal to `inst_pc_i`.
- `ARLEN_M`  out  4  always 0.
- `ARSIZE_M`  out  3  always 3'b010.
- `ARBURST_M`  out  2  always 2'b01 (INCR).
- `ARVALID_M`  out  1  read-address valid.
- `ARREADY_M`  in  1  read-address ready.
- `RID_M`  in  4  ignored.
- `RDATA_M`  in  32  read data.
- `RRESP_M`  in  2  read response.
- `RLAST_M`  in  1  last beat.
- `RVALID_M`  in  1  read-data valid.
- `RREADY_M`  out  1  read-data ready.

## Operation
- FSM states: IDLE, AR, R, WAIT.
- IDLE: entered on reset; all handshake outputs are low. Unconditionally moves to AR on the next edge.
- AR: `ARVALID_M`=1. On `ARVALID_M & ARREADY_M`, go to R.
- R: `RREADY_M`=1. On `RVALID_M & RLAST_M`:
  - capture `RDATA_M` into `inst_o`;
  - capture (`RRESP_M` ≠ 2'b00) into an error flag;
  - go to WAIT.
- R without `RLAST_M`: the beat is accepted and its data is discarded. The FSM stays in R; it never receives a multi-beat burst because `ARLEN_M`=0.
- WAIT:
  - `ifid_en_o` = ~`dmem_busy_i`; `fetch_err_o` = error flag & ~`dmem_busy_i`.
  - When `ifid_en_o`=1, go to AR; the IF stage loads its new PC on the same edge.
  - Otherwise stay in WAIT, holding `inst_o`.
- `ARADDR_M` is combinational from `inst_pc_i`. Its AXI stability is guaranteed because the PC cannot change while `ifid_en_o`=0, and `ifid_en_o` is 0 in AR and R.
- `inst_o` changes only on an R-state capture. It holds through WAIT and the following AR/R states.
- `ifid_en_o` is asserted only in WAIT, for exactly one cycle per fetch.
- Flush and stall from the hazard unit do not affect this block. The IF stage applies them at the `ifid_en_o` edge.

## Timing
- Reset values: state IDLE; `inst_o`=0; `ifid_en_o`, `fetch_err_o`, `ARVALID_M`, `RREADY_M` = 0; error flag = 0.
- Reset asserted mid-transaction drops `ARVALID_M`/`RREADY_M` immediately (asynchronously). Any in-flight AXI transaction is abandoned; the system resets the slave on the same `rst`.
- First `ARVALID_M` appears in the second cycle after reset release (IDLE lasts one cycle).
- Best case, with ARREADY and RVALID both in the cycle they are first sampled:
  - AR 1 cycle, R 1 cycle, WAIT 1 cycle.
  - `ifid_en_o` pulses every 3 cycles.
  - Throughput is 1 instruction / 3 cycles.
- Each extra cycle of ARREADY, RVALID, or `dmem_busy_i` latency adds exactly one cycle.
- `RVALID_M` asserted while not in R is ignored (`RREADY_M`=0 there).
- `dmem_busy_i` toggling in AR/R has no effect. Only its value in WAIT matters.

## Test plan
- Reset, then a zero-wait slave returning 0x00000013 for PC 0x0:
  - `ARVALID_M` rises in cycle 2 with `ARADDR_M`=0x0;
  - `ifid_en_o` pulses in cycle 4 with `inst_o`=0x00000013;
  - the next AR uses PC 0x4.
- ARREADY delayed 3 cycles and RVALID delayed 2 cycles: `ARVALID_M` holds with a stable address; `ifid_en_o` arrives 5 cycles later than the zero-wait case; exactly one pulse.
- `dmem_busy_i` held high for 4 cycles after data capture: `ifid_en_o` stays 0 and `inst_o` holds; the pulse occurs in the first cycle `dmem_busy_i`=0.
- `RRESP_M`=2'b10 with `RDATA_M`=0xDEADBEEF: `inst_o`=0xDEADBEEF, and `fetch_err_o`=1 coincident with `ifid_en_o`. The next fetch with OKAY gives `fetch_err_o`=0.
- `rst` asserted while in R with RVALID pending: `RREADY_M` and `inst_o` clear immediately. After release the sequence restarts from IDLE; no stale `ifid_en_o` pulse.
- Stray `RVALID_M`=1 during AR: no capture, no `ifid_en_o`; normal completion afterward.
